// File: rtl/cpu_io_hub_pkg.sv
// Shared types and the combinational interrupt arbiter used by cpu_io_hub.
package lib_io;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } IO_ARB;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_PEND = 2'd1,
    IRQ_DONE = 2'd2
  } IO_IRQ_STATE;

  localparam int RR_MAX_CH = 16;

  // First set request at or after ptr, wrapping modulo n_ch; 0 when nothing is set.
  // Fixed priority is the same search started at ptr = 0.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] req, input int ptr, input int n_ch);
    int idx;
    int pick;
    pick = 0;
    // Walk from the farthest offset down so the nearest hit is the last one written.
    for (int k = RR_MAX_CH - 1; k >= 0; k--) begin
      if (k < n_ch) begin
        idx = ptr + k;
        if (idx >= n_ch) idx = idx - n_ch;
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/io_wfifo.sv
// Write decoupling FIFO: cpu pushes, device pops, sticky overflow on push-while-full.
module io_wfifo
  import lib_io::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_w_req,
  input  logic [DATA_W-1:0] i_w_data,
  output logic              o_w_busy,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_busy,
  output logic              o_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full is taken from the registered count, so a pop never frees a slot for a same-cycle push.
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_w_req && !w_full;
  assign w_pop   = !w_empty && !i_rd_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_w_req && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_w_data;
  end

  assign o_w_busy   = w_full;
  assign o_rd_valid = !w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_ovf      = r_ovf;

endmodule

// File: rtl/cpu_io_hub.sv
// Merges per-channel interrupts into one cpu irr/ack port and buffers cpu writes to a slow device.
module cpu_io_hub
  import lib_io::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 32,
  parameter int WQ_DEPTH = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_irr,
  output logic [N_CH-1:0]          ch_ack,
  input  logic [N_CH*DATA_W-1:0]   ch_r_data,
  output logic                     cpu_irr,
  input  logic                     cpu_ack,
  output logic [DATA_W-1:0]        cpu_r_data,
  output logic [$clog2(N_CH)-1:0]  cpu_src,
  input  logic                     cpu_w_req,
  input  logic [DATA_W-1:0]        cpu_w_data,
  output logic                     cpu_w_busy,
  output logic                     dev_w_req,
  output logic [DATA_W-1:0]        dev_w_data,
  input  logic                     dev_w_busy,
  output logic                     w_ovf
);

  localparam int SRC_W  = $clog2(N_CH);
  localparam bit USE_RR = (ARB_MODE == int'(ARB_RR));

  IO_IRQ_STATE       r_state;
  IO_IRQ_STATE       w_state_next;
  logic [SRC_W-1:0]  r_ptr;
  logic [SRC_W-1:0]  w_ptr_next;
  logic [SRC_W-1:0]  r_src;
  logic [SRC_W-1:0]  w_src_next;
  logic [DATA_W-1:0] r_r_data;
  logic [DATA_W-1:0] w_r_data_next;
  logic              r_irr;
  logic              w_irr_next;
  logic [N_CH-1:0]   r_ch_ack;
  logic [N_CH-1:0]   w_ch_ack_next;

  logic [DATA_W-1:0]    w_ch_data [N_CH];
  logic [RR_MAX_CH-1:0] w_req_pad;
  logic [SRC_W-1:0]     w_pick;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch_data
    assign w_ch_data[gi] = ch_r_data[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    w_req_pad           = '0;
    w_req_pad[N_CH-1:0] = ch_irr;
  end

  assign w_pick = SRC_W'(rr_pick(w_req_pad, USE_RR ? int'(r_ptr) : 0, N_CH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IRQ_IDLE;
      r_ptr    <= '0;
      r_src    <= '0;
      r_r_data <= '0;
      r_irr    <= 1'b0;
      r_ch_ack <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_src    <= w_src_next;
      r_r_data <= w_r_data_next;
      r_irr    <= w_irr_next;
      r_ch_ack <= w_ch_ack_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_src_next    = r_src;
    w_r_data_next = r_r_data;
    w_irr_next    = r_irr;
    w_ch_ack_next = '0;
    case (r_state)
      IRQ_IDLE: begin
        if (|ch_irr) begin
          w_src_next    = w_pick;
          w_r_data_next = w_ch_data[w_pick];
          w_irr_next    = 1'b1;
          w_state_next  = IRQ_PEND;
        end
      end
      IRQ_PEND: begin
        if (cpu_ack) begin
          w_irr_next            = 1'b0;
          w_ch_ack_next[r_src]  = 1'b1;
          w_ptr_next            = (r_src == SRC_W'(N_CH - 1)) ? '0 : r_src + 1'b1;
          w_state_next          = IRQ_DONE;
        end
      end
      // One idle cycle so the serviced channel can drop its request before re-arbitration.
      IRQ_DONE: w_state_next = IRQ_IDLE;
      default:  w_state_next = IRQ_IDLE;
    endcase
  end

  assign cpu_irr    = r_irr;
  assign cpu_src    = r_src;
  assign cpu_r_data = r_r_data;
  assign ch_ack     = r_ch_ack;

  io_wfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wfifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_w_req    (cpu_w_req),
    .i_w_data   (cpu_w_data),
    .o_w_busy   (cpu_w_busy),
    .o_rd_valid (dev_w_req),
    .o_rd_data  (dev_w_data),
    .i_rd_busy  (dev_w_busy),
    .o_ovf      (w_ovf)
  );

endmodule

// File: tb/tb_cpu_io_hub.sv
// Scoreboard bench: fixed-priority and round-robin hubs share stimulus, each checked against a reference model.
module tb_cpu_io_hub;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    ch_irr;
  logic [N*DW-1:0] ch_r_data;
  logic            cpu_ack;
  logic            cpu_w_req;
  logic [DW-1:0]   cpu_w_data;
  logic            dev_w_busy;

  logic [1:0][N-1:0]  ch_ack;
  logic [1:0]         cpu_irr;
  logic [1:0][DW-1:0] cpu_r_data;
  logic [1:0][1:0]    cpu_src;
  logic [1:0]         cpu_w_busy;
  logic [1:0]         dev_w_req;
  logic [1:0][DW-1:0] dev_w_data;
  logic [1:0]         w_ovf;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    cpu_io_hub #(.N_CH(N), .DATA_W(DW), .WQ_DEPTH(DEPTH), .ARB_MODE(gi)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .ch_irr     (ch_irr),
      .ch_ack     (ch_ack[gi]),
      .ch_r_data  (ch_r_data),
      .cpu_irr    (cpu_irr[gi]),
      .cpu_ack    (cpu_ack),
      .cpu_r_data (cpu_r_data[gi]),
      .cpu_src    (cpu_src[gi]),
      .cpu_w_req  (cpu_w_req),
      .cpu_w_data (cpu_w_data),
      .cpu_w_busy (cpu_w_busy[gi]),
      .dev_w_req  (dev_w_req[gi]),
      .dev_w_data (dev_w_data[gi]),
      .dev_w_busy (dev_w_busy),
      .w_ovf      (w_ovf[gi])
    );
  end

  // Expected outputs for the cycle following one stimulus cycle.
  typedef struct {
    logic [1:0]         irr;
    logic [1:0][1:0]    src;
    logic [1:0][DW-1:0] data;
    logic [1:0][N-1:0]  ack;
    logic               busy;
    logic               req;
    logic               ovf;
    logic [DW-1:0]      head;
  } st_t;

  st_t sq[$];
  st_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;
  bit  active = 0;

  // Reference model state: one interrupt service per hub, one shared write queue.
  bit            m_pend [2];
  bit            m_guard[2];
  int            m_ptr  [2];
  int            m_src  [2];
  logic [DW-1:0] m_data [2];
  logic [DW-1:0] fq[$];
  bit            m_ovf;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 0;
      m_guard[d] = 0;
      m_ptr[d]   = 0;
      m_src[d]   = 0;
      m_data[d]  = '0;
    end
    fq.delete();
    m_ovf = 0;
    sq.delete();
  endtask

  function automatic int pick(input int d, input logic [N-1:0] irr);
    int start;
    start = (d == 0) ? 0 : m_ptr[d];
    for (int k = 0; k < N; k++) begin
      if (irr[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  // Apply one cycle of inputs, predict the outputs after the next edge, then advance past it.
  task automatic apply(input logic [N-1:0] irr, input logic ack, input logic wreq,
                       input logic [DW-1:0] wd, input logic dbusy);
    st_t e;
    int  s;
    bit  was_full;
    bit  do_pop;
    ch_irr     = irr;
    cpu_ack    = ack;
    cpu_w_req  = wreq;
    cpu_w_data = wd;
    dev_w_busy = dbusy;
    for (int w = 0; w < N; w++) ch_r_data[w*DW +: DW] = $urandom;
    e.ack = '0;
    for (int d = 0; d < 2; d++) begin
      if (m_guard[d]) begin
        m_guard[d] = 0;
      end else if (m_pend[d]) begin
        if (ack) begin
          m_pend[d]  = 0;
          m_guard[d] = 1;
          e.ack[d]   = N'(1 << m_src[d]);
          m_ptr[d]   = (m_src[d] + 1) % N;
        end
      end else if (irr != '0) begin
        s          = pick(d, irr);
        m_src[d]   = s;
        m_data[d]  = ch_r_data[s*DW +: DW];
        m_pend[d]  = 1;
      end
      e.irr[d]  = m_pend[d];
      e.src[d]  = 2'(m_src[d]);
      e.data[d] = m_data[d];
    end
    was_full = (fq.size() == DEPTH);
    do_pop   = (fq.size() != 0) && !dbusy;
    if (do_pop) void'(fq.pop_front());
    if (wreq && !was_full) fq.push_back(wd);
    if (wreq && was_full) m_ovf = 1;
    e.busy = (fq.size() == DEPTH);
    e.req  = (fq.size() != 0);
    e.head = e.req ? fq[0] : '0;
    e.ovf  = m_ovf;
    sq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && active) begin
      if (sq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_underrun: got no expected entry at %0t", $time);
      end else begin
        mon_e = sq.pop_front();
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("cpu_irr[%0d]", d), DW'(cpu_irr[d]), DW'(mon_e.irr[d]));
          if (mon_e.irr[d]) begin
            chk($sformatf("cpu_src[%0d]", d), DW'(cpu_src[d]), DW'(mon_e.src[d]));
            chk($sformatf("cpu_r_data[%0d]", d), cpu_r_data[d], mon_e.data[d]);
          end
          chk($sformatf("ch_ack[%0d]", d), DW'(ch_ack[d]), DW'(mon_e.ack[d]));
          chk($sformatf("cpu_w_busy[%0d]", d), DW'(cpu_w_busy[d]), DW'(mon_e.busy));
          chk($sformatf("dev_w_req[%0d]", d), DW'(dev_w_req[d]), DW'(mon_e.req));
          chk($sformatf("w_ovf[%0d]", d), DW'(w_ovf[d]), DW'(mon_e.ovf));
          if (mon_e.req) chk($sformatf("dev_w_data[%0d]", d), dev_w_data[d], mon_e.head);
        end
      end
    end
  end

  task automatic random_phase(input int n, input int busy_pct);
    logic [N-1:0] irr;
    for (int i = 0; i < n; i++) begin
      irr = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, 15));
      apply(irr, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), $urandom,
            ($urandom_range(0, 99) < busy_pct));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    ch_irr     = '0;
    ch_r_data  = '0;
    cpu_ack    = 1'b0;
    cpu_w_req  = 1'b0;
    cpu_w_data = '0;
    dev_w_busy = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_cpu_irr[%0d]", d), DW'(cpu_irr[d]), '0);
      chk($sformatf("rst_ch_ack[%0d]", d), DW'(ch_ack[d]), '0);
      chk($sformatf("rst_cpu_r_data[%0d]", d), cpu_r_data[d], '0);
      chk($sformatf("rst_cpu_src[%0d]", d), DW'(cpu_src[d]), '0);
      chk($sformatf("rst_dev_w_req[%0d]", d), DW'(dev_w_req[d]), '0);
      chk($sformatf("rst_cpu_w_busy[%0d]", d), DW'(cpu_w_busy[d]), '0);
      chk($sformatf("rst_w_ovf[%0d]", d), DW'(w_ovf[d]), '0);
    end
    #1 reset = 1'b1;
    active = 1;

    // Fixed priority with two requesters; channel 1 drops after its ack.
    apply(4'b1010, 0, 0, '0, 0);
    apply(4'b1010, 0, 0, '0, 0);
    apply(4'b1010, 1, 0, '0, 0);
    apply(4'b1000, 0, 0, '0, 0);
    apply(4'b1000, 0, 0, '0, 0);
    apply(4'b1001, 1, 0, '0, 0);
    apply(4'b0000, 0, 0, '0, 0);

    // All channels requesting with immediate acks: round-robin rotation.
    for (int i = 0; i < 16; i++) apply(4'b1111, 1, 0, '0, 0);
    apply(4'b0000, 1, 0, '0, 0);
    apply(4'b0000, 1, 0, '0, 0);

    // Fill to full, overflow once, then drain in order.
    for (int i = 1; i <= 5; i++) apply('0, 0, 1, DW'(i), 1);
    for (int i = 0; i < 6; i++) apply('0, 0, 0, '0, 0);

    // Two entries primed, then steady push+pop streaming.
    apply('0, 0, 1, 32'hA0, 1);
    apply('0, 0, 1, 32'hA1, 1);
    for (int i = 0; i < 10; i++) apply('0, 0, 1, $urandom, 0);
    for (int i = 0; i < 4; i++) apply('0, 0, 0, '0, 0);

    random_phase(300, 30);
    random_phase(200, 75);

    // Quiesce, then reset mid-PEND with three entries queued.
    for (int i = 0; i < 8; i++) apply('0, 1, 0, '0, 0);
    apply(4'b0100, 0, 1, 32'hC1, 1);
    apply(4'b0100, 0, 1, 32'hC2, 1);
    apply(4'b0100, 0, 1, 32'hC3, 1);
    apply(4'b0100, 0, 0, '0, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst_cpu_irr[%0d]", d), DW'(cpu_irr[d]), '0);
      chk($sformatf("arst_dev_w_req[%0d]", d), DW'(dev_w_req[d]), '0);
      chk($sformatf("arst_w_ovf[%0d]", d), DW'(w_ovf[d]), '0);
      chk($sformatf("arst_cpu_w_busy[%0d]", d), DW'(cpu_w_busy[d]), '0);
      chk($sformatf("arst_ch_ack[%0d]", d), DW'(ch_ack[d]), '0);
    end
    active = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    active = 1;
    for (int i = 0; i < 4; i++) apply('0, 1, 0, '0, 0);

    random_phase(200, 50);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", DW'(sq.size()), '0);
    active = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
